// File: rtl/afu_rd_if.sv
// Request-side bundle between the AFU control logic and the c0 read engine.
// The master modport is the engine; the slave modport is its environment.
interface afu_rd_if #(
  parameter int ADDR_W  = 42,
  parameter int MDATA_W = 16
);
  logic               stall;
  logic [2:0]         afu_state;
  logic [ADDR_W-1:0]  ctrl_addr;
  logic               ctrl_rsp_seen;
  logic [ADDR_W-1:0]  run_rd_addr;
  logic [31:0]        run_num_cls;
  logic               rd_valid;
  logic [MDATA_W-1:0] rd_mdata;
  logic [ADDR_W-1:0]  rd_addr;
  logic [31:0]        rd_issued;
  logic               rd_done;

  modport master (
    input  stall, afu_state, ctrl_addr, ctrl_rsp_seen, run_rd_addr, run_num_cls,
    output rd_valid, rd_mdata, rd_addr, rd_issued, rd_done
  );

  modport slave (
    output stall, afu_state, ctrl_addr, ctrl_rsp_seen, run_rd_addr, run_num_cls,
    input  rd_valid, rd_mdata, rd_addr, rd_issued, rd_done
  );
endinterface

// File: rtl/afu_read_engine.sv
// c0 read-request generator: polls the host control line in CTRL and streams
// sequential data-line reads in RUN. All request outputs are registered.
module afu_read_engine #(
  parameter int                   ADDR_W     = 42,
  parameter int                   MDATA_W    = 16,
  parameter logic [MDATA_W-1:0]   CTRL_MDATA = 16'h0001,
  parameter logic [MDATA_W-1:0]   RUN_MDATA  = 16'h0002,
  parameter int                   POLL_GAP   = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  afu_rd_if.master  bus
);

  localparam logic [2:0] ST_CTRL = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam int         GAP_W   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT, P_GAP} poll_state_e;

  poll_state_e        poll_q;
  logic [GAP_W-1:0]   gap_q;
  logic               run_q;
  logic [ADDR_W-1:0]  base_q;
  logic [31:0]        num_q;
  logic [31:0]        issued_q;
  logic               done_q;
  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [MDATA_W-1:0] mdata_q;

  logic               in_ctrl;
  logic               in_run;
  logic               run_start;
  logic               run_emit;
  logic               poll_emit;
  logic [ADDR_W-1:0]  run_addr;
  logic [31:0]        num_d;
  logic [31:0]        issued_d;
  logic               done_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_ctrl   = (bus.afu_state == ST_CTRL);
    in_run    = (bus.afu_state == ST_RUN);
    run_start = in_run && !run_q;
    run_emit  = in_run && run_q && !bus.stall && (issued_q < num_q);
    poll_emit = in_ctrl && (poll_q == P_ISSUE) && !bus.stall;
    run_addr  = base_q + ADDR_W'(issued_q);
    num_d     = run_start ? bus.run_num_cls : num_q;
    issued_d  = '0;
    if (in_run && !run_start) issued_d = issued_q + 32'(run_emit);
    done_d    = in_run && (issued_d == num_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_q   <= P_IDLE;
      gap_q    <= '0;
      run_q    <= 1'b0;
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      mdata_q  <= '0;
    end else begin
      run_q    <= in_run;
      issued_q <= issued_d;
      done_q   <= done_d;
      valid_q  <= poll_emit || run_emit;
      if (run_start) begin
        base_q <= bus.run_rd_addr;
        num_q  <= bus.run_num_cls;
      end
      // Address and tag hold their last value while no request is emitted.
      if (poll_emit) begin
        addr_q  <= bus.ctrl_addr;
        mdata_q <= CTRL_MDATA;
      end else if (run_emit) begin
        addr_q  <= run_addr;
        mdata_q <= RUN_MDATA;
      end

      if (!in_ctrl) begin
        poll_q <= P_IDLE;
      end else begin
        unique case (poll_q)
          P_IDLE:  poll_q <= P_ISSUE;
          P_ISSUE: if (!bus.stall) poll_q <= P_WAIT;
          P_WAIT:  if (bus.ctrl_rsp_seen) begin
                     poll_q <= P_GAP;
                     gap_q  <= '0;
                   end
          P_GAP:   if (gap_q == GAP_LAST) poll_q <= P_ISSUE;
                   else                   gap_q  <= gap_q + 1'b1;
          default: poll_q <= P_IDLE;
        endcase
      end
    end
  end

  assign bus.rd_valid  = valid_q;
  assign bus.rd_addr   = addr_q;
  assign bus.rd_mdata  = mdata_q;
  assign bus.rd_issued = issued_q;
  assign bus.rd_done   = done_q;

endmodule

// File: tb/tb_afu_read_engine.sv
// Directed bench for afu_read_engine: reset, control polling cadence, run streaming,
// stall gaps, address wrap, empty run and early exit from RUN.
module tb_afu_read_engine;

  localparam int ADDR_W = 42;
  localparam int MDATA_W = 16;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  afu_rd_if #(.ADDR_W(ADDR_W), .MDATA_W(MDATA_W)) bus ();

  afu_read_engine #(
    .ADDR_W(ADDR_W), .MDATA_W(MDATA_W),
    .CTRL_MDATA(16'h0001), .RUN_MDATA(16'h0002), .POLL_GAP(16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0]  addr_q[$];
  logic [MDATA_W-1:0] mdata_q[$];
  int                 cyc_q[$];

  // Enter RUN from IDLE, record every request, then return to IDLE.
  task automatic run_case(input logic [ADDR_W-1:0] base, input logic [31:0] num,
                          input int stall_lo, input int stall_hi, input int budget);
    addr_q.delete(); mdata_q.delete(); cyc_q.delete();
    bus.run_rd_addr = base;
    bus.run_num_cls = num;
    bus.stall       = 1'b0;
    bus.afu_state   = 3'd2;
    step();
    check("run_latch_no_req", 64'(bus.rd_valid), 64'd0);
    for (int c = 0; c < budget; c++) begin
      bus.stall = (c >= stall_lo) && (c <= stall_hi);
      step();
      if (bus.rd_valid) begin
        addr_q.push_back(bus.rd_addr);
        mdata_q.push_back(bus.rd_mdata);
        cyc_q.push_back(c);
      end
    end
    bus.stall = 1'b0;
    check("run_done", 64'(bus.rd_done), 64'd1);
    check("run_issued", 64'(bus.rd_issued), 64'(num));
    bus.afu_state = 3'd0;
    step();
  endtask

  int k;
  int cnt;
  logic found;
  logic [ADDR_W-1:0] wrap_exp[4];

  initial begin
    reset_n           = 1'b0;
    bus.stall         = 1'b0;
    bus.afu_state     = 3'd0;
    bus.ctrl_addr     = '0;
    bus.ctrl_rsp_seen = 1'b0;
    bus.run_rd_addr   = '0;
    bus.run_num_cls   = '0;
    #22;
    check("rst_valid",  64'(bus.rd_valid),  64'd0);
    check("rst_issued", 64'(bus.rd_issued), 64'd0);
    check("rst_done",   64'(bus.rd_done),   64'd0);
    check("rst_addr",   64'(bus.rd_addr),   64'd0);
    check("rst_mdata",  64'(bus.rd_mdata),  64'd0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.rd_valid) cnt++;
    end
    check("idle_no_req", 64'(cnt), 64'd0);

    // Control polling: one read, no re-read until a response, then 17-cycle turnaround.
    bus.ctrl_addr = 42'h100;
    bus.afu_state = 3'd1;
    step();
    check("ctrl_enter_no_req", 64'(bus.rd_valid), 64'd0);
    step();
    check("ctrl_rd_valid", 64'(bus.rd_valid), 64'd1);
    check("ctrl_rd_addr",  64'(bus.rd_addr),  64'h100);
    check("ctrl_rd_mdata", 64'(bus.rd_mdata), 64'h0001);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.rd_valid) cnt++;
    end
    check("ctrl_no_reread", 64'(cnt), 64'd0);
    bus.ctrl_rsp_seen = 1'b1;
    step();
    bus.ctrl_rsp_seen = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < 40) begin
      step();
      k++;
      if (bus.rd_valid) found = 1'b1;
    end
    check("ctrl_poll_gap", 64'(k), 64'd17);
    check("ctrl_reread_addr", 64'(bus.rd_addr), 64'h100);
    bus.afu_state = 3'd0;
    step();
    check("ctrl_exit_idle", 64'(bus.rd_valid), 64'd0);

    // Four back-to-back data reads.
    run_case(42'h2000, 32'd4, -1, -2, 6);
    check("run4_count", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < addr_q.size(); i++) begin
      check($sformatf("run4_addr%0d", i),  64'(addr_q[i]),  64'h2000 + 64'(i));
      check($sformatf("run4_mdata%0d", i), 64'(mdata_q[i]), 64'h0002);
      check($sformatf("run4_cyc%0d", i),   64'(cyc_q[i]),   64'(i));
    end
    check("run4_exit_valid", 64'(bus.rd_valid), 64'd0);
    check("run4_exit_done",  64'(bus.rd_done),  64'd0);

    // Three stalled cycles after the second read.
    run_case(42'h3000, 32'd8, 2, 4, 14);
    check("stall_count", 64'(addr_q.size()), 64'd8);
    if (addr_q.size() == 8) begin
      check("stall_gap", 64'(cyc_q[2] - cyc_q[1]), 64'd4);
      for (int i = 0; i < 8; i++)
        check($sformatf("stall_addr%0d", i), 64'(addr_q[i]), 64'h3000 + 64'(i));
    end

    // Address wrap at the top of the cache-line space.
    wrap_exp[0] = 42'h3FFFFFFFFFE;
    wrap_exp[1] = 42'h3FFFFFFFFFF;
    wrap_exp[2] = 42'h0;
    wrap_exp[3] = 42'h1;
    run_case(42'h3FFFFFFFFFE, 32'd4, -1, -2, 6);
    check("wrap_count", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < addr_q.size() && i < 4; i++)
      check($sformatf("wrap_addr%0d", i), 64'(addr_q[i]), 64'(wrap_exp[i]));

    // Empty run: done on the first RUN cycle, no requests.
    bus.run_rd_addr = 42'h4000;
    bus.run_num_cls = 32'd0;
    bus.afu_state   = 3'd2;
    step();
    check("empty_done_first", 64'(bus.rd_done), 64'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.rd_valid) cnt++;
    end
    check("empty_no_req", 64'(cnt), 64'd0);
    bus.afu_state = 3'd0;
    step();

    // Leave RUN after 5 of 10 reads.
    bus.run_rd_addr = 42'h5000;
    bus.run_num_cls = 32'd10;
    bus.afu_state   = 3'd2;
    step();
    for (int i = 0; i < 5; i++) step();
    check("early_issued5", 64'(bus.rd_issued), 64'd5);
    check("early_last_addr", 64'(bus.rd_addr), 64'h5004);
    bus.afu_state = 3'd0;
    step();
    check("early_exit_valid",  64'(bus.rd_valid),  64'd0);
    check("early_exit_issued", 64'(bus.rd_issued), 64'd0);
    check("early_exit_done",   64'(bus.rd_done),   64'd0);

    // Asynchronous reset in the middle of a run.
    bus.afu_state = 3'd2;
    step();
    for (int i = 0; i < 3; i++) step();
    check("mid_pre_valid", 64'(bus.rd_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",  64'(bus.rd_valid),  64'd0);
    check("mid_rst_issued", 64'(bus.rd_issued), 64'd0);
    bus.afu_state = 3'd0;
    step();
    step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.rd_valid) cnt++;
    end
    check("post_rst_idle", 64'(cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
